// File: rtl/io_sw_debounce_if.sv
// Switch-conditioning bundle between the board pins and the debouncer.
// Plain level interface with no valid/ready: i_sw_raw is sampled every clock, the o_* outputs are always valid.
interface io_sw_debounce_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_sw_raw;
  logic [WIDTH-1:0] o_sw;
  logic [WIDTH-1:0] o_sw_rise;
  logic [WIDTH-1:0] o_sw_fall;
  logic             o_tick;
  logic             o_busy;

  modport master (
    output i_sw_raw,
    input  o_sw,
    input  o_sw_rise,
    input  o_sw_fall,
    input  o_tick,
    input  o_busy
  );

  modport slave (
    input  i_sw_raw,
    output o_sw,
    output o_sw_rise,
    output o_sw_fall,
    output o_tick,
    output o_busy
  );
endinterface

// File: rtl/io_sw_debounce.sv
// Two-flop synchroniser plus tick-based per-bit debouncer for the board switches.
// Optional edge pulses (o_sw_rise / o_sw_fall) are built only when SW_EDGE_DETECT_EN is defined.
module io_sw_debounce #(
  parameter int WIDTH        = 32,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 20
) (
  input logic            i_clk,
  input logic            i_reset,
  io_sw_debounce_if.slave sw
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] sw_q;
  logic [WIDTH-1:0] sw_d;
  logic [WIDTH-1:0] upd;
  logic [PW-1:0]    presc;
  logic             tick_q;
  logic             busy;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw.i_sw_raw;
      s2 <= s1;
    end
  end

  // Free-running prescaler; tick_q is high the cycle after presc hits its last value.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc  <= '0;
      tick_q <= 1'b0;
    end else if (presc == PRESC_LAST) begin
      presc  <= '0;
      tick_q <= 1'b1;
    end else begin
      presc  <= presc + PW'(1);
      tick_q <= 1'b0;
    end
  end

  // Any cycle where the synchronised level matches o_sw clears that bit's count.
  always_comb begin
    upd = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2[i] == sw_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick_q) begin
        if (cnt_q[i] == CNT_LAST) begin
          upd[i]   = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    sw_d = sw_q ^ upd;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sw_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sw_q <= sw_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < WIDTH; i++) busy = busy | (cnt_q[i] != '0);
  end

`ifdef SW_EDGE_DETECT_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Registered with the o_sw update, so a pulse lines up with the new level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= upd & s2;
      fall_q <= upd & ~s2;
    end
  end

  assign sw.o_sw_rise = rise_q;
  assign sw.o_sw_fall = fall_q;
`else
  assign sw.o_sw_rise = '0;
  assign sw.o_sw_fall = '0;
`endif

  assign sw.o_sw   = sw_q;
  assign sw.o_tick = tick_q;
  assign sw.o_busy = busy;

endmodule

// File: tb/tb_io_sw_debounce.sv
// Bench for io_sw_debounce: main DUT with TICK_DIV=4/STABLE_TICKS=3, plus a TICK_DIV=1/STABLE_TICKS=1 instance.
module tb_io_sw_debounce;
  localparam int W = 32;

`ifdef SW_EDGE_DETECT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_sw_debounce_if #(.WIDTH(W)) bus ();
  io_sw_debounce_if #(.WIDTH(W)) bus1 ();

  io_sw_debounce #(.WIDTH(W), .TICK_DIV(4), .STABLE_TICKS(3)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .sw      (bus.slave)
  );

  io_sw_debounce #(.WIDTH(W), .TICK_DIV(1), .STABLE_TICKS(1)) dut_fast (
    .i_clk   (clk),
    .i_reset (rst),
    .sw      (bus1.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] raw;
    int           lo;
    int           hi;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive(input logic [W-1:0] v);
    @(negedge clk);
    bus.i_sw_raw = v;
    exp_q.push_back(v);
  endtask

  // Waits for o_sw to leave old_sw, then checks word, edge pulses, latency, pulse width.
  task automatic wait_change(input string name, input logic [W-1:0] old_sw, input int lo, input int hi);
    int lat;
    bit seen;
    logic [W-1:0] exp_sw;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= hi + 4; n++) begin
      @(negedge clk);
      if (!seen && bus.o_sw !== old_sw) begin
        seen = 1'b1;
        lat  = n;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL %s_queue: got empty expected entry", name);
          exp_sw = old_sw;
        end else begin
          exp_sw = exp_q.pop_front();
        end
        check({name, "_sw"}, bus.o_sw, exp_sw);
        check({name, "_rise"}, bus.o_sw_rise, {W{EDGE_EN}} & exp_sw & ~old_sw);
        check({name, "_fall"}, bus.o_sw_fall, {W{EDGE_EN}} & old_sw & ~exp_sw);
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %h expected change from %h", name, bus.o_sw, old_sw);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else begin
      check_range({name, "_latency"}, lat, lo, hi);
      @(negedge clk);
      check({name, "_rise_end"}, bus.o_sw_rise, '0);
      check({name, "_fall_end"}, bus.o_sw_fall, '0);
      check({name, "_busy_end"}, {31'd0, bus.o_busy}, '0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] prev;
    logic [W-1:0] acc_sw, acc_rise, acc_fall;
    bit busy_seen;

    vecs[0] = '{raw: 32'h0000_0001, lo: 11, hi: 14};
    vecs[1] = '{raw: 32'h0000_FFFF, lo: 11, hi: 14};
    vecs[2] = '{raw: 32'hFFFF_0000, lo: 11, hi: 14};
    vecs[3] = '{raw: 32'hA5A5_5A5A, lo: 11, hi: 14};
    vecs[4] = '{raw: 32'hFFFF_FFFF, lo: 11, hi: 14};
    vecs[5] = '{raw: 32'h0000_0000, lo: 11, hi: 14};

    rst = 1'b1;
    bus.i_sw_raw  = '0;
    bus1.i_sw_raw = '0;
    repeat (3) @(negedge clk);
    check("rst_sw",   bus.o_sw, '0);
    check("rst_rise", bus.o_sw_rise, '0);
    check("rst_fall", bus.o_sw_fall, '0);
    check("rst_tick", {31'd0, bus.o_tick}, '0);
    check("rst_busy", {31'd0, bus.o_busy}, '0);
    check("rst_fast_tick", {31'd0, bus1.o_tick}, '0);
    rst = 1'b0;

    // Clean transitions, including all 32 bits swapping at once.
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].raw);
      wait_change($sformatf("vec%0d", i), prev, vecs[i].lo, vecs[i].hi);
      prev = vecs[i].raw;
    end

    // Glitch on bit 3 for 5 cycles.
    acc_sw = '0; acc_rise = '0; acc_fall = '0; busy_seen = 1'b0;
    @(negedge clk);
    bus.i_sw_raw = 32'h0000_0008;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (n == 4) bus.i_sw_raw = '0;
      acc_sw   = acc_sw | bus.o_sw;
      acc_rise = acc_rise | bus.o_sw_rise;
      acc_fall = acc_fall | bus.o_sw_fall;
      busy_seen = busy_seen | bus.o_busy;
    end
    check("glitch_sw", acc_sw, '0);
    check("glitch_rise", acc_rise, '0);
    check("glitch_fall", acc_fall, '0);
    check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_end", {31'd0, bus.o_busy}, '0);

    // Bounce on bit 7 (1,0,1,0 each held 2 cycles), then settle high.
    acc_sw = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.i_sw_raw = (k % 2 == 0) ? 32'h0000_0080 : 32'h0;
      @(negedge clk);
      acc_sw = acc_sw | bus.o_sw;
    end
    acc_sw = acc_sw | bus.o_sw;
    check("bounce_quiet", acc_sw, '0);
    drive(32'h0000_0080);
    wait_change("bounce", 32'h0, 11, 14);

    drive(32'h0);
    wait_change("clear", 32'h0000_0080, 11, 14);

    // Reset asynchronously while counters are running.
    @(negedge clk);
    bus.i_sw_raw = 32'hA5A5_A5A5;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rmid_sw",   bus.o_sw, '0);
    check("rmid_rise", bus.o_sw_rise, '0);
    check("rmid_fall", bus.o_sw_fall, '0);
    check("rmid_tick", {31'd0, bus.o_tick}, '0);
    check("rmid_busy", {31'd0, bus.o_busy}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'hA5A5_A5A5);
    wait_change("rmid", 32'h0, 11, 14);

    // Fast instance: tick every cycle, one-tick stability.
    @(negedge clk);
    bus1.i_sw_raw = 32'h1234_5678;
    for (int n = 1; n <= 6; n++) begin
      logic [W-1:0] e;
      @(negedge clk);
      e = (n >= 3) ? 32'h1234_5678 : 32'h0;
      check($sformatf("fast_sw_%0d", n), bus1.o_sw, e);
      check($sformatf("fast_tick_%0d", n), {31'd0, bus1.o_tick}, 32'd1);
      check($sformatf("fast_rise_%0d", n), bus1.o_sw_rise,
            (n == 3) ? ({W{EDGE_EN}} & 32'h1234_5678) : 32'h0);
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
